// File: rtl/idecode_stage.sv
// idecode_stage
//   Decode stage of the 5-stage RISC-V pipeline, parametrised on datapath
//   width (XLEN) and register-address width (REG_AW). It decodes InstrD and
//   reads the register file, bypassing a same-cycle writeback. It also
//   sign-extends the immediate. All results are then registered into the
//   ID/EX pipeline register.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   InstrD, PCD, PCPlus4D instruction in decode and its PC / PC+4
//   ValidD                InstrD holds a real instruction
//   StallE, FlushE        hold / bubble the ID/EX register (flush wins)
//   RegWriteW, RdW,
//   ResultW               writeback port into the register file
//   *E outputs            registered ID/EX contents for the execute stage
//
// Flow control: ValidD qualifies InstrD. There is no ready signal; the
// hazard unit applies back-pressure through StallE and kills through
// FlushE. A word is accepted on a rising edge only when FlushE = 0 and
// StallE = 0.
module idecode_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              ValidD,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [XLEN-1:0]   ResultW,
  output logic              ValidE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic              IllegalE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE
);

  localparam int NREG = 1 << REG_AW;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;

  // Field slicing
  logic [6:0]        op;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;

  assign op     = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rs1    = InstrD[15 +: REG_AW];
  assign rs2    = InstrD[20 +: REG_AW];
  assign rd     = InstrD[7 +: REG_AW];

  // An index is out of range when any 5-bit field bit above REG_AW is set.
  // This only matters for reduced register files (RV32E); with REG_AW = 5
  // the shift clears the field and the check is constant-false.
  logic rs1_oob;
  logic rs2_oob;
  logic rd_oob;

  assign rs1_oob = (InstrD[19:15] >> REG_AW) != 5'd0;
  assign rs2_oob = (InstrD[24:20] >> REG_AW) != 5'd0;
  assign rd_oob  = (InstrD[11:7]  >> REG_AW) != 5'd0;

  // Main decoder
  logic       reg_write;
  logic       mem_write;
  logic       jump;
  logic       branch;
  logic       alu_src;
  logic [1:0] result_src;
  logic [1:0] alu_op;
  imm_src_t   imm_src;
  logic       op_legal;
  logic       use_rs1;
  logic       use_rs2;
  logic       use_rd;

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    result_src = 2'b00;
    alu_op     = 2'b00;
    imm_src    = IMM_I;
    op_legal   = 1'b1;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    case (op)
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
        use_rs1    = 1'b1;
        use_rd     = 1'b1;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_src   = IMM_S;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        use_rd    = 1'b1;
      end
      OP_BEQ: begin
        branch  = 1'b1;
        alu_op  = 2'b01;
        imm_src = IMM_B;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_I: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b10;
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        result_src = 2'b10;
        imm_src    = IMM_J;
        use_rd     = 1'b1;
      end
      default: op_legal = 1'b0;
    endcase
  end

  // ALU decoder. op[5] separates R-type (sub possible) from I-ALU, where
  // bit 30 is just an immediate bit and must not turn addi into sub.
  logic [2:0] alu_ctl;
  logic       funct3_legal;

  always_comb begin
    alu_ctl      = 3'b000;
    funct3_legal = 1'b1;
    case (alu_op)
      2'b01: alu_ctl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_ctl = (op[5] && InstrD[30]) ? 3'b001 : 3'b000;
          3'b010:  alu_ctl = 3'b101;
          3'b110:  alu_ctl = 3'b011;
          3'b111:  alu_ctl = 3'b010;
          default: funct3_legal = 1'b0;
        endcase
      end
      default: alu_ctl = 3'b000;
    endcase
  end

  logic illegal;
  logic kill;

  assign illegal = !op_legal || !funct3_legal ||
                   (use_rs1 && rs1_oob) || (use_rs2 && rs2_oob) || (use_rd && rd_oob);
  // Illegal or invalid words must not have any side effects downstream.
  assign kill = illegal || !ValidD;

  // Immediate extension
  logic [XLEN-1:0] imm_ext;

  always_comb begin
    case (imm_src)
      IMM_S:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                          InstrD[11:8], 1'b0};
      IMM_J:   imm_ext = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                          InstrD[30:21], 1'b0};
      default: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  // Register file. Entry 0 is never written, so it stays at its reset value.
  logic [XLEN-1:0] rf [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i[REG_AW-1:0]] <= '0;
      end
    end else if (RegWriteW && (RdW != '0)) begin
      rf[RdW] <= ResultW;
    end
  end

  // Reads bypass a same-cycle writeback so a write followed by a read of the
  // same register needs no bubble.
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  always_comb begin
    if (rs1 == '0)                        rd1 = '0;
    else if (RegWriteW && (RdW == rs1))   rd1 = ResultW;
    else                                  rd1 = rf[rs1];
  end

  always_comb begin
    if (rs2 == '0)                        rd2 = '0;
    else if (RegWriteW && (RdW == rs2))   rd2 = ResultW;
    else                                  rd2 = rf[rs2];
  end

  // ID/EX register. While stalled, RD1E/RD2E keep their old values even if
  // the register file is written underneath; the hazard unit forwards on
  // Rs1E/Rs2E to cover that.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ValidE      <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      IllegalE    <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
    end else if (FlushE) begin
      ValidE      <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      IllegalE    <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
    end else if (!StallE) begin
      ValidE      <= ValidD;
      RegWriteE   <= reg_write && !kill;
      MemWriteE   <= mem_write && !kill;
      JumpE       <= jump && !kill;
      BranchE     <= branch && !kill;
      ALUSrcE     <= alu_src && !kill;
      IllegalE    <= illegal && ValidD;
      ResultSrcE  <= kill ? 2'b00 : result_src;
      ALUControlE <= kill ? 3'b000 : alu_ctl;
      Rs1E        <= rs1;
      Rs2E        <= rs2;
      RdE         <= rd;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
    end
  end

endmodule

// File: tb/tb_idecode_stage.sv
module tb_idecode_stage;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic        illegal;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } e_t;
  localparam int EW = $bits(e_t);

  // ctl = {valid, reg_write, mem_write, jump, branch, alu_src, illegal}
  typedef struct packed {
    logic [31:0] ins;
    logic [6:0]  ctl;
    logic [1:0]  rs;
    logic [2:0]  alu;
    logic [31:0] imm;
    logic        imm_dc;
  } vec_t;

  // clock / reset and DUT signals
  logic        clk;
  logic        reset;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        stall_e;
  logic        flush_e;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;

  logic        valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, illegal_e;
  logic [1:0]  result_src_e;
  logic [2:0]  alu_ctl_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e;

  // second instance: XLEN = 64, RV32E register file
  logic [63:0] pc_d2, pc_plus4_d2, result_w2;
  logic [3:0]  rd_w2;
  logic        valid_e2, reg_write_e2, mem_write_e2, jump_e2, branch_e2, alu_src_e2, illegal_e2;
  logic [1:0]  result_src_e2;
  logic [2:0]  alu_ctl_e2;
  logic [3:0]  rs1_e2, rs2_e2, rd_e2;
  logic [63:0] pc_e2, pc_plus4_e2, rd1_e2, rd2_e2, imm_e2;

  assign pc_plus4_d  = pc_d + 32'd4;
  assign pc_d2       = {32'h0, pc_d};
  assign pc_plus4_d2 = pc_d2 + 64'd4;
  assign rd_w2       = rd_w[3:0];
  assign result_w2   = {32'hA5A5_A5A5, result_w};

  e_t obs;
  assign obs = {valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, illegal_e,
                result_src_e, alu_ctl_e, rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e};

  idecode_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .InstrD(instr_d), .PCD(pc_d), .PCPlus4D(pc_plus4_d),
    .ValidD(valid_d), .StallE(stall_e), .FlushE(flush_e), .RegWriteW(reg_write_w),
    .RdW(rd_w), .ResultW(result_w),
    .ValidE(valid_e), .RegWriteE(reg_write_e), .MemWriteE(mem_write_e), .JumpE(jump_e),
    .BranchE(branch_e), .ALUSrcE(alu_src_e), .IllegalE(illegal_e), .ResultSrcE(result_src_e),
    .ALUControlE(alu_ctl_e), .Rs1E(rs1_e), .Rs2E(rs2_e), .RdE(rd_e), .PCE(pc_e),
    .PCPlus4E(pc_plus4_e), .RD1E(rd1_e), .RD2E(rd2_e), .ImmExtE(imm_e)
  );

  idecode_stage #(.XLEN(64), .REG_AW(4)) dut2 (
    .clk(clk), .reset(reset), .InstrD(instr_d), .PCD(pc_d2), .PCPlus4D(pc_plus4_d2),
    .ValidD(valid_d), .StallE(stall_e), .FlushE(flush_e), .RegWriteW(reg_write_w),
    .RdW(rd_w2), .ResultW(result_w2),
    .ValidE(valid_e2), .RegWriteE(reg_write_e2), .MemWriteE(mem_write_e2), .JumpE(jump_e2),
    .BranchE(branch_e2), .ALUSrcE(alu_src_e2), .IllegalE(illegal_e2), .ResultSrcE(result_src_e2),
    .ALUControlE(alu_ctl_e2), .Rs1E(rs1_e2), .Rs2E(rs2_e2), .RdE(rd_e2), .PCE(pc_e2),
    .PCPlus4E(pc_plus4_e2), .RD1E(rd1_e2), .RD2E(rd2_e2), .ImmExtE(imm_e2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // scoreboard and register model
  logic [EW-1:0] exp_q[$];
  logic [31:0]   model_rf [32];
  int            tests_run;
  int            tests_failed;

  function automatic logic [31:0] rf_model(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (reg_write_w && (rd_w == idx)) return result_w;
    return model_rf[idx];
  endfunction

  function automatic e_t mk(input logic [6:0] ctl, input logic [1:0] rs, input logic [2:0] alu,
                            input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm);
    e_t e;
    {e.valid, e.reg_write, e.mem_write, e.jump, e.branch, e.alu_src, e.illegal} = ctl;
    e.result_src = rs;
    e.alu_ctl    = alu;
    e.rs1        = ins[19:15];
    e.rs2        = ins[24:20];
    e.rd         = ins[11:7];
    e.pc         = pc;
    e.pc4        = pc + 32'd4;
    e.rd1        = rf_model(ins[19:15]);
    e.rd2        = rf_model(ins[24:20]);
    e.imm        = imm;
    return e;
  endfunction

  // driver tasks
  task automatic set_in(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                        input logic stall, input logic flush, input logic wen,
                        input logic [4:0] waddr, input logic [31:0] wdata);
    instr_d     = ins;
    pc_d        = pc;
    valid_d     = v;
    stall_e     = stall;
    flush_e     = flush;
    reg_write_w = wen;
    rd_w        = waddr;
    result_w    = wdata;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset && reg_write_w && (rd_w != 5'd0)) model_rf[rd_w] = result_w;
    #1;
  endtask

  task automatic test_reset();
    e_t got, want;
    #2;
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL reset_async got=%h want=0", obs);
    end
    tests_run++;
    if ({valid_e2, reg_write_e2, mem_write_e2, jump_e2, branch_e2, alu_src_e2, illegal_e2,
         result_src_e2, alu_ctl_e2, rs1_e2, rs2_e2, rd_e2, pc_e2, pc_plus4_e2, rd1_e2,
         rd2_e2, imm_e2} !== '0) begin
      tests_failed++;
      $display("FAIL reset_async_dut2 valid=%b imm=%h want all zero", valid_e2, imm_e2);
    end
    @(negedge clk);
    reset = 1'b1;
    set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    exp_q.push_back(mk(7'b0000000, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0));
    step();
    got = obs; want = exp_q.pop_front();
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL reset_idle got=%h want=%h", got, want);
    end
  endtask

  task automatic test_write_read();
    e_t got, want;
    set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_00AA);
    step();
    set_in(32'h0052_8313, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    exp_q.push_back(mk(7'b1100010, 2'b00, 3'b000, 32'h0052_8313, 32'h100, 32'h5));
    step();
    got = obs; want = exp_q.pop_front();
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL addi_after_write got=%h want=%h", got, want);
    end
    tests_run++;
    if (rd1_e !== 32'hAA || rd_e !== 5'd6) begin
      tests_failed++;
      $display("FAIL addi_rd1 rd1=%h rd=%0d want rd1=aa rd=6", rd1_e, rd_e);
    end
  endtask

  task automatic test_bypass_x0();
    e_t got, want;
    // add x8, x7, x0 while x7 is being written
    set_in(32'h0003_8433, 32'h104, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234);
    exp_q.push_back(mk(7'b1100000, 2'b00, 3'b000, 32'h0003_8433, 32'h104, 32'h0));
    step();
    got = obs; want = exp_q.pop_front();
    got.imm = '0; want.imm = '0;
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL add_bypass got=%h want=%h", got, want);
    end
    tests_run++;
    if (rd1_e !== 32'h1234 || rd2_e !== 32'h0) begin
      tests_failed++;
      $display("FAIL bypass_values rd1=%h rd2=%h want 1234/0", rd1_e, rd2_e);
    end
    // write x0 = 0xFF while reading x0, then read x0 again
    set_in(32'h0000_0433, 32'h108, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFF);
    step();
    tests_run++;
    if (rd1_e !== 32'h0 || rd2_e !== 32'h0) begin
      tests_failed++;
      $display("FAIL x0_write_bypass rd1=%h rd2=%h want 0/0", rd1_e, rd2_e);
    end
    set_in(32'h0000_0433, 32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    tests_run++;
    if (rd1_e !== 32'h0 || rd2_e !== 32'h0) begin
      tests_failed++;
      $display("FAIL x0_read rd1=%h rd2=%h want 0/0", rd1_e, rd2_e);
    end
  endtask

  task automatic test_back_to_back();
    vec_t tbl [9];
    e_t   got, want;
    tbl[0] = '{32'hFE20_8CE3, 7'b1000100, 2'b00, 3'b001, 32'hFFFF_FFF8, 1'b0}; // beq -8
    tbl[1] = '{32'h0010_00EF, 7'b1101000, 2'b10, 3'b000, 32'h0000_0800, 1'b0}; // jal +2048
    tbl[2] = '{32'h4031_00B3, 7'b1100000, 2'b00, 3'b001, 32'h0,         1'b1}; // sub
    tbl[3] = '{32'h0021_6533, 7'b1100000, 2'b00, 3'b011, 32'h0,         1'b1}; // or
    tbl[4] = '{32'h0021_7533, 7'b1100000, 2'b00, 3'b010, 32'h0,         1'b1}; // and
    tbl[5] = '{32'hFFF0_A593, 7'b1100010, 2'b00, 3'b101, 32'hFFFF_FFFF, 1'b0}; // slti -1
    tbl[6] = '{32'h0062_8223, 7'b1010010, 2'b00, 3'b000, 32'h0000_0004, 1'b0}; // sw
    tbl[7] = '{32'h0082_A483, 7'b1100010, 2'b01, 3'b000, 32'h0000_0008, 1'b0}; // lw
    tbl[8] = '{32'hC000_8093, 7'b1100010, 2'b00, 3'b000, 32'hFFFF_FC00, 1'b0}; // addi -1024
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].ins, 32'h400 + 32'(i * 4), 1'b1, 1'b0, 1'b0,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      exp_q.push_back(mk(tbl[i].ctl, tbl[i].rs, tbl[i].alu, tbl[i].ins,
                         32'h400 + 32'(i * 4), tbl[i].imm));
      step();
      got = obs; want = exp_q.pop_front();
      if (tbl[i].imm_dc) begin
        got.imm = '0; want.imm = '0;
      end
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL b2b_%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_stall_flush();
    e_t got, want, held;
    held = mk(7'b1100010, 2'b01, 3'b000, 32'h0082_A483, 32'h200, 32'h8);
    set_in(32'h0082_A483, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    exp_q.push_back(held);
    step();
    got = obs; want = exp_q.pop_front();
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL stall_load got=%h want=%h", got, want);
    end
    for (int k = 0; k < 3; k++) begin
      set_in(32'h0021_6533, 32'h204, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h55 + 32'(k));
      exp_q.push_back(held);
      step();
      got = obs; want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d got=%h want=%h", k, got, want);
      end
    end
    // writes made during the stall must be visible afterwards
    set_in(32'h0052_8313, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    exp_q.push_back(mk(7'b1100010, 2'b00, 3'b000, 32'h0052_8313, 32'h208, 32'h5));
    step();
    got = obs; want = exp_q.pop_front();
    tests_run++;
    if (got !== want || rd1_e !== 32'h57) begin
      tests_failed++;
      $display("FAIL post_stall_read got=%h want=%h", got, want);
    end
    set_in(32'h0082_A483, 32'h20C, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    exp_q.push_back('0);
    step();
    got = obs; want = exp_q.pop_front();
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL flush_and_stall got=%h want=%h", got, want);
    end
    set_in(32'h0052_8313, 32'h210, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    set_in(32'h0052_8313, 32'h214, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    exp_q.push_back('0);
    step();
    got = obs; want = exp_q.pop_front();
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL flush_only got=%h want=%h", got, want);
    end
  endtask

  task automatic test_illegal();
    vec_t tbl [4];
    logic [31:0] ins;
    logic        v;
    e_t          got, want;
    tbl[0] = '{32'hFFFF_FFFF, 7'b1000001, 2'b00, 3'b000, 32'h0, 1'b1}; // bad opcode
    tbl[1] = '{32'h0020_9033, 7'b1000001, 2'b00, 3'b000, 32'h0, 1'b1}; // R funct3 001
    tbl[2] = '{32'h0082_A483, 7'b0000000, 2'b00, 3'b000, 32'h0, 1'b1}; // lw, invalid
    tbl[3] = '{32'hFFFF_FFFF, 7'b0000000, 2'b00, 3'b000, 32'h0, 1'b1}; // bad, invalid
    for (int i = 0; i < 4; i++) begin
      ins = tbl[i].ins;
      v   = tbl[i].ctl[6];
      set_in(ins, 32'h500, v, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      exp_q.push_back(mk(tbl[i].ctl, tbl[i].rs, tbl[i].alu, ins, 32'h500, 32'h0));
      step();
      got = obs; want = exp_q.pop_front();
      tests_run++;
      if ({got.valid, got.reg_write, got.mem_write, got.jump, got.branch, got.alu_src,
           got.illegal, got.result_src, got.alu_ctl} !==
          {want.valid, want.reg_write, want.mem_write, want.jump, want.branch, want.alu_src,
           want.illegal, want.result_src, want.alu_ctl}) begin
        tests_failed++;
        $display("FAIL illegal_%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_rv32e_xlen64();
    // add x17, x1, x2: rd index out of range for 16 registers
    set_in(32'h0020_88B3, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    tests_run++;
    if (illegal_e2 !== 1'b1 || reg_write_e2 !== 1'b0 || valid_e2 !== 1'b1 || rd_e2 !== 4'd1) begin
      tests_failed++;
      $display("FAIL rv32e_x17 ill=%b rw=%b v=%b rd=%0d want 1/0/1/1",
               illegal_e2, reg_write_e2, valid_e2, rd_e2);
    end
    // add x3, x1, x2 is fine
    set_in(32'h0020_81B3, 32'h604, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    tests_run++;
    if (illegal_e2 !== 1'b0 || reg_write_e2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL rv32e_x3 ill=%b rw=%b want 0/1", illegal_e2, reg_write_e2);
    end
    // lw x3, -4(x1): unused rs2 field has bit 4 set, still legal; x1 bypassed
    set_in(32'hFFC0_A183, 32'h608, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11);
    step();
    tests_run++;
    if (imm_e2 !== 64'hFFFF_FFFF_FFFF_FFFC || illegal_e2 !== 1'b0 || result_src_e2 !== 2'b01) begin
      tests_failed++;
      $display("FAIL xlen64_lw imm=%h ill=%b rs=%b want fffffffffffffffc/0/01",
               imm_e2, illegal_e2, result_src_e2);
    end
    tests_run++;
    if (rd1_e2 !== 64'hA5A5_A5A5_0000_0011 || pc_plus4_e2 !== 64'h60C) begin
      tests_failed++;
      $display("FAIL xlen64_data rd1=%h pc4=%h want a5a5a5a500000011/60c", rd1_e2, pc_plus4_e2);
    end
    // lw x16, -4(x1): rd out of range
    set_in(32'hFFC0_A803, 32'h60C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    tests_run++;
    if (illegal_e2 !== 1'b1 || reg_write_e2 !== 1'b0 || illegal_e !== 1'b0) begin
      tests_failed++;
      $display("FAIL rv32e_lw_x16 ill2=%b rw2=%b ill=%b want 1/0/0", illegal_e2, reg_write_e2, illegal_e);
    end
  endtask

  task automatic test_reset_mid();
    e_t got, want;
    set_in(32'h0052_8313, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    tests_run++;
    if (valid_e !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_valid got=%b want=1", valid_e);
    end
    #3;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i[4:0]] = 32'h0;
    #1;
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs got=%h want=0", obs);
    end
    tests_run++;
    if (valid_e2 !== 1'b0 || imm_e2 !== 64'h0 || pc_e2 !== 64'h0) begin
      tests_failed++;
      $display("FAIL midreset_dut2 v=%b imm=%h pc=%h want 0", valid_e2, imm_e2, pc_e2);
    end
    @(negedge clk);
    reset = 1'b1;
    set_in(32'h0052_8313, 32'h304, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    exp_q.push_back(mk(7'b1100010, 2'b00, 3'b000, 32'h0052_8313, 32'h304, 32'h5));
    step();
    got = obs; want = exp_q.pop_front();
    tests_run++;
    if (got !== want || rd1_e !== 32'h0) begin
      tests_failed++;
      $display("FAIL post_reset_rf got=%h want=%h", got, want);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 32; i++) model_rf[i[4:0]] = 32'h0;
    reset = 1'b1;
    set_in(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1 reset = 1'b0;
    test_reset();
    test_write_read();
    test_bypass_x0();
    test_back_to_back();
    test_stall_flush();
    test_illegal();
    test_rv32e_xlen64();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
